dram_result_unloader: RTL

Downstream drain stage for the multi-core matrix processor. After the processor finishes, this block reads a contiguous range of DRAM result words, each CORES*8 bits wide. It serialises each word into bytes on a valid/ready byte stream for a UART or host link. While active it takes the shared DRAM address and read port through an external mux selected by bus_own.

---
 rtl/dram_result_unloader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/dram_result_unloader.sv
// Purpose: drains a contiguous range of DRAM result words into a byte stream, MSB lane first.
// Latency: RD_LAT+1 cycles per word to fetch it, then one cycle per byte when tx_ready stays high.
// Backpressure: tx_data/tx_valid hold while tx_ready is low; the FSM stalls in SEND or CSUM.
// Optional: define UNLOAD_CHECKSUM_EN to append an 8-bit running-sum byte after the data.
module dram_result_unloader #(
    parameter int CORES  = 6,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W-1:0]     word_count,
    output logic                  bus_own,
    output logic [ADDR_W-1:0]     dram_addr,
    input  logic [CORES*8-1:0]    dram_q,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int W     = CORES * 8;
    localparam int IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CORES - 1);
    localparam logic [1:0]       LAT_INIT = 2'(RD_LAT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_LOAD = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;
`ifdef UNLOAD_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd6;
`endif

    logic [2:0]        state_q, state_d;
    logic              start_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] dram_addr_q, dram_addr_d;
    logic              bus_own_q, bus_own_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;
    logic [1:0]        lat_q, lat_d;
`ifdef UNLOAD_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              start_edge;
    logic              xfer;
    logic [W-1:0]      shreg_shl;

    assign start_edge = start & ~start_q;
    assign xfer       = tx_valid_q & tx_ready;
    assign shreg_shl  = shreg_q << 8;

    assign bus_own   = bus_own_q;
    assign dram_addr = dram_addr_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Next-state logic: sequences fetch (ADDR/WAIT/LOAD) and byte serialisation (SEND).
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        dram_addr_d = dram_addr_q;
        bus_own_d   = bus_own_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        shreg_d     = shreg_q;
        byte_idx_d  = byte_idx_q;
        lat_d       = lat_q;
`ifdef UNLOAD_CHECKSUM_EN
        sum_d       = sum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    addr_d = base_addr;
                    cnt_d  = word_count;
                    busy_d = 1'b1;
`ifdef UNLOAD_CHECKSUM_EN
                    sum_d  = 8'h00;
`endif
                    if (word_count == '0) begin
`ifdef UNLOAD_CHECKSUM_EN
                        // An empty unload still carries its (zero) checksum byte.
                        state_d    = S_CSUM;
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b1;
`else
                        state_d = S_FIN;
`endif
                    end else begin
                        // Address is registered on entry so it is stable for the whole fetch.
                        state_d     = S_ADDR;
                        bus_own_d   = 1'b1;
                        dram_addr_d = base_addr;
                    end
                end
            end

            S_ADDR: begin
                lat_d   = LAT_INIT;
                state_d = (RD_LAT == 1) ? S_LOAD : S_WAIT;
            end

            S_WAIT: begin
                lat_d = lat_q - 2'd1;
                if (lat_q <= 2'd1) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                shreg_d    = dram_q;
                tx_data_d  = dram_q[W-1 -: 8];
                tx_valid_d = 1'b1;
                byte_idx_d = '0;
                state_d    = S_SEND;
            end

            S_SEND: begin
                if (xfer) begin
`ifdef UNLOAD_CHECKSUM_EN
                    sum_d = sum_q + tx_data_q;
`endif
                    if (byte_idx_q != LAST_IDX) begin
                        shreg_d    = shreg_shl;
                        tx_data_d  = shreg_shl[W-1 -: 8];
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end else begin
                        tx_valid_d = 1'b0;
                        addr_d     = addr_q + ADDR_W'(1);
                        cnt_d      = cnt_q - ADDR_W'(1);
                        if (cnt_q > ADDR_W'(1)) begin
                            state_d     = S_ADDR;
                            dram_addr_d = addr_q + ADDR_W'(1);
                        end else begin
                            // Release the shared DRAM port as soon as the last data byte leaves.
                            bus_own_d = 1'b0;
`ifdef UNLOAD_CHECKSUM_EN
                            state_d    = S_CSUM;
                            tx_data_d  = sum_q + tx_data_q;
                            tx_valid_d = 1'b1;
`else
                            state_d = S_FIN;
`endif
                        end
                    end
                end
            end

`ifdef UNLOAD_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_FIN;
                end
            end
`endif

            S_FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                bus_own_d = 1'b0;
                state_d   = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            dram_addr_q <= '0;
            bus_own_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            shreg_q     <= '0;
            byte_idx_q  <= '0;
            lat_q       <= 2'd0;
`ifdef UNLOAD_CHECKSUM_EN
            sum_q       <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= start;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            dram_addr_q <= dram_addr_d;
            bus_own_q   <= bus_own_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            shreg_q     <= shreg_d;
            byte_idx_q  <= byte_idx_d;
            lat_q       <= lat_d;
`ifdef UNLOAD_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

endmodule
